// File: rtl/mem_dbus_ctrl.sv
// Memory-stage data bus controller: issues one bus access per load/store,
// stalls the pipeline until it completes, and returns aligned, extended load data.
//   state | meaning
//   IDLE  | no access outstanding; a new access may start
//   REQ   | data_req asserted, waiting for addr_ok
//   WAIT  | address accepted, waiting for data_ok
//   DONE  | access finished; load result valid for one cycle
//   DRAIN | cancelled access finished on the bus; result discarded
module mem_dbus_ctrl (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        dce,
  input  logic [31:0] daddr,
  input  logic [3:0]  dre,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  input  logic [7:0]  memtype,
  input  logic        exc_valid,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        stall_o,
  output logic        load_valid_o,
  output logic [31:0] load_data_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_cancel;
  logic        r_req;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [4:0]  r_ld_type;
  logic        r_load_valid;
  logic [31:0] r_load_data;

  logic        w_start;
  logic        w_cancel;
  logic [1:0]  w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  assign w_start = !reset && (r_state == S_IDLE) && dce && (|(dre | we))
                   && !exc_valid && !flush;

  // A flush arriving in the completing cycle still discards the result.
  assign w_cancel = r_cancel | flush;

  always_comb begin
    w_size = 2'd2;
    if (memtype[0] | memtype[1] | memtype[5])
      w_size = 2'd0;
    else if (memtype[2] | memtype[3] | memtype[6])
      w_size = 2'd1;
  end

  always_comb begin
    w_byte = data_rdata[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = data_rdata[7:0];
      2'd1: w_byte = data_rdata[15:8];
      2'd2: w_byte = data_rdata[23:16];
      2'd3: w_byte = data_rdata[31:24];
      default: w_byte = data_rdata[7:0];
    endcase
    w_half = r_addr[1] ? data_rdata[31:16] : data_rdata[15:0];

    w_load_ext = data_rdata;
    if (r_ld_type[0])
      w_load_ext = {{24{w_byte[7]}}, w_byte};
    else if (r_ld_type[1])
      w_load_ext = {24'd0, w_byte};
    else if (r_ld_type[2])
      w_load_ext = {{16{w_half[15]}}, w_half};
    else if (r_ld_type[3])
      w_load_ext = {16'd0, w_half};
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cancel     <= 1'b0;
      r_req        <= 1'b0;
      r_wr         <= 1'b0;
      r_size       <= 2'd0;
      r_addr       <= 32'd0;
      r_wstrb      <= 4'd0;
      r_wdata      <= 32'd0;
      r_ld_type    <= 5'd0;
      r_load_valid <= 1'b0;
      r_load_data  <= 32'd0;
    end else begin
      r_load_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cancel <= 1'b0;
          if (w_start) begin
            r_addr    <= daddr;
            r_wr      <= |we;
            r_wstrb   <= we;
            r_wdata   <= din;
            r_size    <= w_size;
            r_ld_type <= memtype[4:0];
            r_req     <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush) r_cancel <= 1'b1;
          if (data_addr_ok) begin
            r_req <= 1'b0;
            if (data_data_ok) begin
              if (w_cancel) begin
                r_state <= S_DRAIN;
              end else begin
                r_state <= S_DONE;
                if (!r_wr) begin
                  r_load_valid <= 1'b1;
                  r_load_data  <= w_load_ext;
                end
              end
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (flush) r_cancel <= 1'b1;
          if (data_data_ok) begin
            if (w_cancel) begin
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_DONE;
              if (!r_wr) begin
                r_load_valid <= 1'b1;
                r_load_data  <= w_load_ext;
              end
            end
          end
        end
        S_DONE: begin
          r_cancel <= 1'b0;
          r_state  <= S_IDLE;
        end
        S_DRAIN: begin
          r_cancel <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_cancel <= 1'b0;
          r_req    <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign data_req     = r_req;
  assign data_wr      = r_wr;
  assign data_size    = r_size;
  assign data_addr    = r_addr;
  assign data_wstrb   = r_wr ? r_wstrb : 4'd0;
  assign data_wdata   = r_wdata;
  assign load_valid_o = r_load_valid;
  assign load_data_o  = r_load_data;
  assign stall_o      = w_start || (r_state == S_REQ) || (r_state == S_WAIT)
                        || (r_state == S_DRAIN);

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Randomized bench for mem_dbus_ctrl: directed corner cases plus random
// loads/stores with random bus delays and flushes, checked against a simple model.
module tb_mem_dbus_ctrl;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        dce;
  logic [31:0] daddr;
  logic [3:0]  dre;
  logic [3:0]  we;
  logic [31:0] din;
  logic [7:0]  memtype;
  logic        exc_valid;
  logic        flush;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        stall_o;
  logic        load_valid_o;
  logic [31:0] load_data_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_ld   = 32'd0;

  mem_dbus_ctrl dut (
    .cpu_clk(cpu_clk), .reset(reset), .dce(dce), .daddr(daddr), .dre(dre),
    .we(we), .din(din), .memtype(memtype), .exc_valid(exc_valid), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .stall_o(stall_o), .load_valid_o(load_valid_o),
    .load_data_o(load_data_o)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // t: 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 sb, 6 sh, 7 sw
  // ad: cycles before addr_ok; dd: cycles from addr_ok to data_ok; fl: active cycle of flush (-1 none)
  task automatic run_txn(input int t, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int ad, input int dd, input int fl);
    logic [3:0]  en;
    logic [1:0]  sz;
    logic [31:0] b, h, ext;
    int          off, c;
    bit          is_ld, cancel;
    off    = int'(addr[1:0]);
    is_ld  = (t < 5);
    cancel = (fl >= 0);
    if (t == 0 || t == 1 || t == 5)      sz = 2'd0;
    else if (t == 2 || t == 3 || t == 6) sz = 2'd1;
    else                                 sz = 2'd2;
    if (sz == 2'd0)      en = 4'b0001 << off;
    else if (sz == 2'd1) en = (off >= 2) ? 4'b1100 : 4'b0011;
    else                 en = 4'b1111;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (t)
      0:       ext = (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      1:       ext = b;
      2:       ext = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3:       ext = h;
      default: ext = rd;
    endcase

    chk("idle_stall", 32'(stall_o), 32'd0);
    dce = 1'b1; daddr = addr; din = wd; memtype = 8'b1 << t;
    dre = is_ld ? en : 4'd0;
    we  = is_ld ? 4'd0 : en;
    #1;
    chk("start_stall", 32'(stall_o), 32'd1);
    chk("start_req", 32'(data_req), 32'd0);
    @(negedge cpu_clk);
    dce = 1'b0; dre = 4'd0; we = 4'd0; memtype = 8'd0; din = ~wd; daddr = $urandom;
    c = 0;
    for (int k = 0; k <= ad; k++) begin
      chk("req_req", 32'(data_req), 32'd1);
      chk("req_wr", 32'(data_wr), is_ld ? 32'd0 : 32'd1);
      chk("req_size", 32'(data_size), 32'(sz));
      chk("req_addr", data_addr, addr);
      chk("req_wstrb", 32'(data_wstrb), is_ld ? 32'd0 : 32'(en));
      chk("req_wdata", data_wdata, wd);
      chk("req_stall", 32'(stall_o), 32'd1);
      data_addr_ok = (k == ad);
      data_data_ok = (k == ad) && (dd == 0);
      data_rdata   = data_data_ok ? rd : $urandom;
      flush        = (c == fl);
      c++;
      @(negedge cpu_clk);
    end
    for (int j = 1; j <= dd; j++) begin
      chk("wait_req", 32'(data_req), 32'd0);
      chk("wait_stall", 32'(stall_o), 32'd1);
      data_addr_ok = 1'b0;
      data_data_ok = (j == dd);
      data_rdata   = data_data_ok ? rd : $urandom;
      flush        = (c == fl);
      c++;
      @(negedge cpu_clk);
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0; flush = 1'b0; data_rdata = $urandom;
    if (is_ld && !cancel) exp_ld = ext;
    chk("end_stall", 32'(stall_o), cancel ? 32'd1 : 32'd0);
    chk("end_lvalid", 32'(load_valid_o), (is_ld && !cancel) ? 32'd1 : 32'd0);
    chk("end_ldata", load_data_o, exp_ld);
    chk("end_req", 32'(data_req), 32'd0);
    @(negedge cpu_clk);
    chk("post_stall", 32'(stall_o), 32'd0);
    chk("post_lvalid", 32'(load_valid_o), 32'd0);
    chk("post_ldata", load_data_o, exp_ld);
  endtask

  initial begin
    int t, off, ad, dd, total, fl;
    logic [31:0] a;
    reset = 1'b1; dce = 1'b0; daddr = 32'd0; dre = 4'd0; we = 4'd0; din = 32'd0;
    memtype = 8'd0; exc_valid = 1'b0; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    repeat (3) @(negedge cpu_clk);
    reset = 1'b0;
    @(negedge cpu_clk);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_wr", 32'(data_wr), 32'd0);
    chk("rst_size", 32'(data_size), 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wstrb", 32'(data_wstrb), 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_lvalid", 32'(load_valid_o), 32'd0);
    chk("rst_ldata", load_data_o, 32'd0);

    run_txn(0, 32'h8000_0003, 32'h5555_5555, 32'h80FF_FFFF, 0, 0, -1);
    chk("lb_result", load_data_o, 32'hFFFF_FF80);
    run_txn(6, 32'h8000_0002, 32'h1234_1234, 32'h0, 3, 0, -1);
    run_txn(3, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 0, 5, -1);
    chk("lhu_result", load_data_o, 32'h0000_BEEF);
    run_txn(4, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 1, 3, 2);
    chk("flush_keep", load_data_o, 32'h0000_BEEF);

    // exception or flush in IDLE suppresses the access
    dce = 1'b1; daddr = 32'h8000_0020; dre = 4'hF; memtype = 8'h10; exc_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin exc_valid = 1'b0; flush = 1'b1; end
      #1;
      chk("exc_stall", 32'(stall_o), 32'd0);
      @(negedge cpu_clk);
      chk("exc_req", 32'(data_req), 32'd0);
    end
    dce = 1'b0; dre = 4'd0; memtype = 8'd0; exc_valid = 1'b0; flush = 1'b0;
    @(negedge cpu_clk);

    // reset during WAIT, then a late data_ok
    dce = 1'b1; daddr = 32'h8000_0040; dre = 4'hF; memtype = 8'h10; din = 32'h1111_2222;
    @(negedge cpu_clk);
    dce = 1'b0; dre = 4'd0; memtype = 8'd0; data_addr_ok = 1'b1;
    @(negedge cpu_clk);
    data_addr_ok = 1'b0;
    chk("rw_wait_stall", 32'(stall_o), 32'd1);
    reset = 1'b1;
    @(negedge cpu_clk);
    reset = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    @(negedge cpu_clk);
    data_data_ok = 1'b0;
    exp_ld = 32'd0;
    chk("rw_req", 32'(data_req), 32'd0);
    chk("rw_stall", 32'(stall_o), 32'd0);
    chk("rw_addr", data_addr, 32'd0);
    chk("rw_wdata", data_wdata, 32'd0);
    chk("rw_wr", 32'(data_wr), 32'd0);
    chk("rw_lvalid", 32'(load_valid_o), 32'd0);
    chk("rw_ldata", load_data_o, 32'd0);
    @(negedge cpu_clk);
    chk("rw_lvalid2", 32'(load_valid_o), 32'd0);
    chk("rw_stall2", 32'(stall_o), 32'd0);

    for (int n = 0; n < 300; n++) begin
      t = $urandom_range(7);
      off = $urandom_range(3);
      if (t == 2 || t == 3 || t == 6) off = off & 2;
      else if (t == 4 || t == 7) off = 0;
      a = {$urandom, 2'b00} | 32'(off);
      ad = $urandom_range(3);
      dd = $urandom_range(4);
      total = ad + 1 + dd;
      fl = -1;
      if (total >= 2 && $urandom_range(3) == 0) fl = $urandom_range(total - 2);
      run_txn(t, a, $urandom, $urandom, ad, dd, fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
